// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//
// Load/store initiator for a word-addressed single-port data RAM with a
// combinational read port and a write port that commits on posedge clk when
// mem_we is high. Byte-addressed RV32I requests are turned into RAM cycles:
//   - loads  (LB/LH/LW/LBU/LHU): one read cycle, then lane select + extension
//   - SW                        : one direct write cycle
//   - SB/SH                     : read the word, merge the lane, write it back
// Misaligned accesses and illegal funct3 codes are answered with rsp_err and
// never drive the RAM.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   req_valid     core request valid
//   req_ready     request accepted when high (only while idle)
//   req_we        1 = store, 0 = load
//   req_funct3    RV32I funct3 (access size / signedness)
//   req_addr      byte address; bits above the RAM word index are ignored
//   req_wdata     store data (low byte/half used by SB/SH)
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     extended load data (0 for stores and errors), held
//   rsp_err       misaligned or illegal access, held
//   mem_we        RAM write enable
//   mem_addr      RAM word address
//   mem_wdata     RAM write data
//   mem_rdata     RAM read data (combinational from mem_addr)
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // funct3[1:0] encodes the access size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t                  state_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [2:0]              f3_q;
    logic [1:0]              lo_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    accept_d;
    logic                    bad_d;
    logic [ADDR_WIDTH-1:0]   word_d;
    logic [DATA_WIDTH-1:0]   load_d;
    logic [DATA_WIDTH-1:0]   merge_d;

    // Address bits above the RAM index wrap around and are intentionally dropped
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        end else begin
            ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                 (f3 == 3'd4) || (f3 == 3'd5);
        end
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            SZ_H:    mis = lo[0];
            SZ_W:    mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Select the addressed little-endian lane and sign/zero-extend it
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [2:0]            f3,
        input logic [1:0]            lo
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    r = {{(DATA_WIDTH-8){b[7]}}, b};
            3'd1:    r = {{(DATA_WIDTH-16){h[15]}}, h};
            3'd4:    r = {{(DATA_WIDTH-8){1'b0}}, b};
            3'd5:    r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of the old word with the store data
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] old,
        input logic [2:0]            f3,
        input logic [1:0]            lo,
        input logic [DATA_WIDTH-1:0] wd
    );
        logic [DATA_WIDTH-1:0] r;
        r = old;
        case (f3[1:0])
            SZ_B:    r[{lo, 3'b000} +: 8]     = wd[7:0];
            SZ_H:    r[{lo[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Request decode and datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        accept_d = req_valid & req_ready_q;
        word_d   = req_addr[ADDR_WIDTH+1:2];
        bad_d    = ~is_legal(req_we, req_funct3) |
                   is_misaligned(req_funct3, req_addr[1:0]);
        load_d   = load_extend(mem_rdata, f3_q, lo_q);
        merge_d  = store_merge(mem_rdata, f3_q, lo_q, wdata_q);
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f3_q        <= 3'd0;
            lo_q        <= 2'd0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        f3_q        <= req_funct3;
                        lo_q        <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        mem_addr_q  <= word_d;
                        req_ready_q <= 1'b0;
                        if (bad_d) begin
                            // Errors skip the RAM entirely and answer next cycle
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else if (!req_we) begin
                            state_q <= S_LOAD;
                        end else if (req_funct3[1:0] == SZ_W) begin
                            state_q     <= S_WRITE;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_LOAD: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= load_d;
                    rsp_err_q   <= 1'b0;
                end
                S_READ: begin
                    state_q     <= S_WRITE;
                    mem_wdata_q <= merge_d;
                end
                S_WRITE: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // The write strobe is gated by rst so a reset cycle can never commit a write
    assign mem_we    = (state_q == S_WRITE) & ~rst;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
